// File: rtl/sample_ring_writer.sv
// Buffers alternating EMG/ECG samples into per-channel RAM rings via port B,
// yielding the port to VGA reads whenever they are requested.
module sample_ring_writer #(
    parameter int unsigned SAMPLE_INTERVAL = 125000,
    parameter int unsigned DEPTH           = 640,
    parameter logic [11:0] CH0_BASE        = 12'h800,
    parameter logic [11:0] CH1_BASE        = 12'hC00,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] emg_in,
    input  logic [31:0] ecg_in,
    input  logic        vga_req,
    input  logic [11:0] vga_addr,
    output logic [11:0] addr_b,
    output logic        wen_b,
    output logic [31:0] din_b,
    output logic        vga_grant,
    output logic [9:0]  ch0_idx,
    output logic [9:0]  ch1_idx,
    output logic        overflow,
    input  logic        overflow_clr
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [17:0]      TICK_LAST = 18'(SAMPLE_INTERVAL - 1);
    localparam logic [9:0]       IDX_LAST  = 10'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

    logic [17:0]      tick_cnt_q, tick_cnt_d;
    logic             sel_q, sel_d;
    logic [9:0]       ch0_idx_q, ch0_idx_d;
    logic [9:0]       ch1_idx_q, ch1_idx_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [11:0]      addr_b_q, addr_b_d;
    logic             wen_b_q, wen_b_d;
    logic [31:0]      din_b_q, din_b_d;
    logic             vga_grant_q, vga_grant_d;
    logic             overflow_q, overflow_d;

    // Entry layout: {channel, sample}
    logic [32:0] fifo_mem [FIFO_DEPTH];

    logic        tick, pop, push, drop;
    logic        head_ch;
    logic [31:0] head_data;
    logic [9:0]  head_idx;
    logic [11:0] head_base;
    logic [32:0] push_entry;

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        pop        = !vga_req && (fifo_cnt_q != '0);
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        push       = tick && ((fifo_cnt_q != FIFO_FULL) || pop);
        drop       = tick && !push;
        push_entry = {sel_q, (sel_q ? ecg_in : emg_in)};
        {head_ch, head_data} = fifo_mem[rd_ptr_q];
        head_base  = head_ch ? CH1_BASE : CH0_BASE;
        head_idx   = head_ch ? ch1_idx_q : ch0_idx_q;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    always_comb begin
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 18'd1;
        sel_d       = tick ? !sel_q : sel_q;
        ch0_idx_d   = ch0_idx_q;
        ch1_idx_d   = ch1_idx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        addr_b_d    = addr_b_q;
        din_b_d     = din_b_q;
        wen_b_d     = 1'b0;
        vga_grant_d = 1'b0;
        overflow_d  = overflow_q;

        if (overflow_clr) overflow_d = 1'b0;
        if (drop)         overflow_d = 1'b1;

        if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        if (vga_req) begin
            addr_b_d    = vga_addr;
            vga_grant_d = 1'b1;
        end else if (pop) begin
            addr_b_d = head_base + {2'b00, head_idx};
            din_b_d  = head_data;
            wen_b_d  = 1'b1;
            if (head_ch) begin
                ch1_idx_d = (ch1_idx_q == IDX_LAST) ? '0 : ch1_idx_q + 10'd1;
            end else begin
                ch0_idx_d = (ch0_idx_q == IDX_LAST) ? '0 : ch0_idx_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            sel_q       <= 1'b0;
            ch0_idx_q   <= '0;
            ch1_idx_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            addr_b_q    <= '0;
            wen_b_q     <= 1'b0;
            din_b_q     <= '0;
            vga_grant_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            sel_q       <= sel_d;
            ch0_idx_q   <= ch0_idx_d;
            ch1_idx_q   <= ch1_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            addr_b_q    <= addr_b_d;
            wen_b_q     <= wen_b_d;
            din_b_q     <= din_b_d;
            vga_grant_q <= vga_grant_d;
            overflow_q  <= overflow_d;
        end
    end

    assign addr_b    = addr_b_q;
    assign wen_b     = wen_b_q;
    assign din_b     = din_b_q;
    assign vga_grant = vga_grant_q;
    assign ch0_idx   = ch0_idx_q;
    assign ch1_idx   = ch1_idx_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/sample_ring_writer.md
# sample_ring_writer

Buffers EMG/ECG samples from `adc_data_capture` and writes them into per-channel circular buffers in data RAM port B. It time-shares port B with the VGA display read path, and VGA has priority. It sits between the ADC capture block and the dual-port `RAM`, and replaces the ad-hoc sample-counter/mux logic in the top level. A small FIFO absorbs samples that arrive while VGA holds the port.

## Interface
- `SAMPLE_INTERVAL`, 125000: clock cycles between sample ticks; range 2..2^18.
- `DEPTH`, 640: entries per channel ring; range 1..1024.
- `CH0_BASE`, 12'h800: RAM word base of the EMG ring.
- `CH1_BASE`, 12'hC00: RAM word base of the ECG ring.
- `FIFO_DEPTH`, 4: pending-sample FIFO entries; power of 2.

- `clock  in  1`: system clock.
- `reset  in  1`: asynchronous, active-high.
- `emg_in  in  32`: current EMG sample (channel 0).
- `ecg_in  in  32`: current ECG sample (channel 1).
- `vga_req  in  1`: VGA requests a port-B read this cycle.
- `vga_addr  in  12`: VGA read word address.
- `addr_b  out  12`: RAM port-B address (registered).
- `wen_b  out  1`: RAM port-B write enable (registered).
- `din_b  out  32`: RAM port-B write data (registered).
- `vga_grant  out  1`: registered; 1 when `addr_b` carries the VGA address.
- `ch0_idx  out  10`: next write index of the EMG ring.
- `ch1_idx  out  10`: next write index of the ECG ring.
- `overflow  out  1`: sticky flag; a sample was dropped.
- `overflow_clr  in  1`: clears `overflow`.

## Operation
- **Tick counter.** 18-bit counter counts 0..SAMPLE_INTERVAL-1 and wraps. `tick` = (counter == SAMPLE_INTERVAL-1).
- **Channel alternation.** `sel` starts at 0 after reset and toggles on every tick.
- **Push on tick.**
  - Entry {ch=sel, data = sel ? ecg_in : emg_in} is pushed. Data is sampled in the tick cycle itself, with no stale mux.
  - The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped and `overflow` is set. `sel` still toggles.
- **Arbitration, every cycle, registered.**
  - `vga_req`=1: `addr_b`←`vga_addr`, `wen_b`←0, `vga_grant`←1. No pop.
  - `vga_req`=0 and FIFO non-empty: pop the head. `addr_b`←base[ch]+idx[ch] (mod 4096), `din_b`←data, `wen_b`←1, `vga_grant`←0. Then idx[ch]←(idx[ch]==DEPTH-1) ? 0 : idx[ch]+1.
  - Otherwise: `wen_b`←0, `vga_grant`←0, `addr_b` holds its value.
- **FIFO ordering.** FIFO order is preserved, so writes across both channels occur in tick order.
- **`din_b`.** Holds its last value whenever `wen_b`=0.
- **`overflow`.** Set has priority over `overflow_clr` in the same cycle.
- **Reset** (async, also when asserted mid-operation):
  - counter, `sel`, `ch0_idx`, `ch1_idx`, FIFO pointers and count: 0.
  - `addr_b`=0, `wen_b`=0, `din_b`=0, `vga_grant`=0, `overflow`=0.
  - Pending samples are discarded. No partial write is issued after reset deasserts.

## Timing
- Edge k = k-th rising edge after reset release.
- **Ticks.** The counter reaches SAMPLE_INTERVAL-1 after edge SAMPLE_INTERVAL-1. The first push happens at edge SAMPLE_INTERVAL.
- **Tick-to-write latency.** Earliest `wen_b`=1 is after edge SAMPLE_INTERVAL+1, i.e. tick-to-write = 2 edges when VGA is idle.
- **VGA read path.** `vga_addr` reaches `addr_b` 1 edge after it is presented. RAM read data is valid 1 further edge later, so VGA data arrives 2 cycles after the request. The VGA controller pipelines for this.
- **Write rate.** At most one write per cycle. The FIFO drains back-to-back while `vga_req`=0.
- **Overflow condition.** With `vga_req` held high, overflow occurs on the (FIFO_DEPTH+1)-th tick.
- **Index outputs.** `ch*_idx` update on the same edge that registers the corresponding write.

## Test plan
- **First writes.** SAMPLE_INTERVAL=8, `vga_req`=0, `emg_in`=32'hA5, `ecg_in`=32'h5A, reset released.
  - After edge 9: `wen_b`=1, `addr_b`=12'h800, `din_b`=32'hA5.
  - After edge 17: `addr_b`=12'hC00, `din_b`=32'h5A.
  - `ch0_idx`=1 and `ch1_idx`=1 afterwards.
- **Ring wrap.** DEPTH=4, 10 ticks.
  - EMG addresses: 800, 801, 802, 803, 800.
  - `ch0_idx` sequence: 1, 2, 3, 0, 1.
- **VGA priority.** `vga_req`=1 for 40 cycles with `vga_addr`=12'h123, SAMPLE_INTERVAL=8.
  - `addr_b`=12'h123 and `vga_grant`=1 from edge 1.
  - `wen_b` stays 0 throughout.
  - 5th tick dropped and `overflow`=1.
  - After release: exactly 4 consecutive writes, in tick order.
- **Overflow clear.**
  - `overflow_clr` pulsed alone: `overflow`=0 next edge.
  - `overflow_clr` pulsed in the same cycle as a drop: `overflow` stays 1.
- **Full FIFO with pop.** FIFO full, tick coincides with a pop: the push is accepted, count stays 4, `overflow` stays 0.
- **Reset mid-operation.** Reset asserted for 1 cycle with 3 entries pending.
  - All outputs go to 0 immediately (asynchronous).
  - No write occurs before edge SAMPLE_INTERVAL+1 after release.
